scan_chain_driver: RTL and testbench

- Test-side driver for a chain of scan flops with asynchronous reset.
- Drives SCE/SCD into the chain head and serially loads a parallel pattern, then issues one functional capture clock.
- Unloads the chain tail into a parallel response register and compares it against an expected vector.
- Sits between the DFT/BIST sequencer and any scan chain built from the library's scan flip-flops.

---
 rtl/scan_drv_pkg.sv | 18 +
 rtl/scan_piso_sipo.sv | 40 ++++
 rtl/scan_chain_driver.sv | 145 ++++++++++++++
 tb/tb_scan_chain_driver.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_drv_pkg.sv
// Shared types and constants for the scan chain driver and its shift register.
package scan_drv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int CAPTURE_CYCLES = 1;

  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/scan_piso_sipo.sv
// Pattern shifter (parallel load, MSB-first serial out) and response shifter
// (serial in, MSB-first fill) for the scan chain driver.
module scan_piso_sipo #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         load,
  input  logic [W-1:0] par_in,
  input  logic         shift_out,
  output logic         ser_out,
  input  logic         shift_in,
  input  logic         ser_in,
  output logic [W-1:0] par_out
);

  logic [W-1:0] pat_q;

  // Zeros fill behind the pattern, so ser_out idles low once the load is done.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      pat_q <= '0;
    end else if (load) begin
      pat_q <= par_in;
    end else if (shift_out) begin
      pat_q <= {pat_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      par_out <= '0;
    end else if (shift_in) begin
      par_out <= {par_out[W-2:0], ser_in};
    end
  end

  assign ser_out = pat_q[W-1];

endmodule

// File: rtl/scan_chain_driver.sv
// Loads a pattern into a scan chain, issues one capture clock, unloads the
// response and compares it against the expected vector.
//
// state   | meaning
// IDLE    | waiting for start, chain controls parked low
// LOAD    | shifting pattern into the chain, MSB first
// CAPTURE | one functional clock with sce low
// UNLOAD  | shifting the captured response out of the chain tail
// DONE    | done pulse, response and mismatch valid
module scan_chain_driver
  import scan_drv_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_so,
  output logic                 sce,
  output logic                 scd,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 mismatch
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic [CHAIN_LEN-1:0] expected_q;
  logic                 cnt_last;
  logic                 cap_last;
  logic                 load_pat;
  logic                 shift_pat;
  logic                 shift_rsp;
  logic                 sce_nx;
  logic                 busy_nx;
  logic                 done_nx;
  logic                 mismatch_nx;

  assign cnt_last = (cnt == CNT_W'(CHAIN_LEN - 1));
  assign cap_last = (cnt == CNT_W'(CAPTURE_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state      <= IDLE;
      cnt        <= '0;
      sce        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mismatch   <= 1'b0;
      expected_q <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sce      <= sce_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      mismatch <= mismatch_nx;
      if (load_pat) begin
        expected_q <= expected;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        if (cnt_last) begin
          state_nx = CAPTURE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        if (cap_last) begin
          state_nx = UNLOAD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      UNLOAD: begin
        if (cnt_last) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    load_pat    = (state == IDLE) && start;
    shift_pat   = (state == LOAD);
    shift_rsp   = (state == UNLOAD);
    sce_nx      = (state_nx == LOAD) || (state_nx == UNLOAD);
    busy_nx     = (state_nx == LOAD) || (state_nx == CAPTURE) || (state_nx == UNLOAD);
    done_nx     = (state_nx == DONE);
    mismatch_nx = mismatch;
    // Compare against the response including the bit arriving on this edge.
    if (shift_rsp && cnt_last) begin
      mismatch_nx = ({response[CHAIN_LEN-2:0], scan_so} != expected_q);
    end
  end

  scan_piso_sipo #(
    .W(CHAIN_LEN)
  ) u_shift (
    .CLK      (CLK),
    .RESETB   (RESETB),
    .load     (load_pat),
    .par_in   (pattern),
    .shift_out(shift_pat),
    .ser_out  (scd),
    .shift_in (shift_rsp),
    .ser_in   (scan_so),
    .par_out  (response)
  );

endmodule

// File: tb/tb_scan_chain_driver.sv
// Bench for scan_chain_driver driving a four-flop scan chain model.
module tb_scan_chain_driver;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] rsp;
    logic         mm;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RESETB = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic [N-1:0] cap_fixed = '0;
  logic         mirror = 1'b0;
  logic         sce, scd, busy, done, mismatch;
  logic [N-1:0] response;
  logic [N-1:0] chain_q;
  logic [N-1:0] cap_d;
  logic         scan_so;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  // Chain of scan flops: Q of flop i feeds SCD of flop i+1.
  assign cap_d   = mirror ? chain_q : cap_fixed;
  assign scan_so = chain_q[N-1];

  always @(posedge CLK or negedge RESETB) begin
    if (!RESETB) chain_q <= '0;
    else if (sce) chain_q <= {chain_q[N-2:0], scd};
    else chain_q <= cap_d;
  end

  scan_chain_driver #(
    .CHAIN_LEN(N)
  ) dut (
    .CLK     (CLK),
    .RESETB  (RESETB),
    .start   (start),
    .pattern (pattern),
    .expected(expected),
    .scan_so (scan_so),
    .sce     (sce),
    .scd     (scd),
    .busy    (busy),
    .done    (done),
    .response(response),
    .mismatch(mismatch)
  );

  // Runs one sequence and records what was observed in cycles 1..11 after
  // the start edge; smask[c] drives start during cycle c.
  task automatic run_seq(input logic [N-1:0] pat, input logic [N-1:0] exp_v,
                         input logic [N-1:0] cap, input logic mir, input logic pre,
                         input logic [11:0] smask,
                         output int done_cyc, output int done_w, output int busy_cyc,
                         output logic [11:0] sce_tr, output logic [11:0] scd_tr,
                         output logic [N-1:0] chain_cap, output logic [N-1:0] chain_done,
                         output logic [N-1:0] rsp, output logic mm);
    done_cyc = 0; done_w = 0; busy_cyc = 0;
    sce_tr = '0; scd_tr = '0; chain_cap = '0; chain_done = '1;
    rsp = 'x; mm = 1'bx;
    cap_fixed = cap;
    mirror = mir;
    if (!pre) @(negedge CLK);
    pattern = pat;
    expected = exp_v;
    start = 1'b1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge CLK);
      sce_tr[cyc] = sce;
      scd_tr[cyc] = scd;
      if (busy) busy_cyc++;
      if (cyc == N + 1) chain_cap = chain_q;
      if (done) begin
        done_w++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          rsp = response;
          mm = mismatch;
          chain_done = chain_q;
        end
      end
      start = smask[cyc];
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({sce, scd, busy, done, mismatch} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {sce, scd, busy, done, mismatch});
    end
    checks++;
    if (response !== '0) begin
      errors++;
      $display("FAIL reset_rsp got %b want 0000", response);
    end
    @(negedge CLK);
    RESETB = 1'b1;
  endtask

  task automatic test_basic;
    int dc, dw, bc;
    logic [11:0] st, dt;
    logic [N-1:0] cc, cd, r;
    logic m;
    exp_t e;
    exp_q.push_back('{rsp: 4'b0110, mm: 1'b0});
    run_seq(4'b1011, 4'b0110, 4'b0110, 1'b0, 1'b0, 12'h000, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e.rsp) begin errors++; $display("FAIL basic_rsp got %b want %b", r, e.rsp); end
    checks++;
    if (m !== e.mm) begin errors++; $display("FAIL basic_mismatch got %b want %b", m, e.mm); end
    checks++;
    if (dc != 2 * N + 2) begin errors++; $display("FAIL basic_latency got %0d want %0d", dc, 2 * N + 2); end
    checks++;
    if (bc != 2 * N + 1) begin errors++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, 2 * N + 1); end
    checks++;
    if (cc !== 4'b1011) begin errors++; $display("FAIL basic_chain_at_capture got %b want 1011", cc); end
    checks++;
    if (cd !== 4'b0000) begin errors++; $display("FAIL basic_chain_after got %b want 0000", cd); end
    checks++;
    if (response !== e.rsp) begin errors++; $display("FAIL basic_rsp_hold got %b want %b", response, e.rsp); end
  endtask

  task automatic test_fault;
    int dc, dw, bc;
    logic [11:0] st, dt;
    logic [N-1:0] cc, cd, r;
    logic m;
    exp_t e;
    exp_q.push_back('{rsp: 4'b0110, mm: 1'b1});
    run_seq(4'b1011, 4'b0111, 4'b0110, 1'b0, 1'b0, 12'h000, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e.rsp) begin errors++; $display("FAIL fault_rsp got %b want %b", r, e.rsp); end
    checks++;
    if (m !== e.mm) begin errors++; $display("FAIL fault_mismatch got %b want %b", m, e.mm); end
    checks++;
    if (dw != 1) begin errors++; $display("FAIL fault_done_width got %0d want 1", dw); end
    checks++;
    if (mismatch !== 1'b1) begin errors++; $display("FAIL fault_mismatch_hold got %b want 1", mismatch); end
  endtask

  task automatic test_waveform;
    int dc, dw, bc;
    logic [11:0] st, dt, exp_sce, exp_scd;
    logic [N-1:0] cc, cd, r;
    logic [N-1:0] pat;
    logic m;
    pat = 4'b1011;
    exp_sce = '0;
    exp_scd = '0;
    for (int k = 0; k < N; k++) begin
      exp_sce[k + 1] = 1'b1;
      exp_sce[k + N + 2] = 1'b1;
      exp_scd[k + 1] = pat[N - 1 - k];
    end
    run_seq(pat, 4'b0110, 4'b0110, 1'b0, 1'b0, 12'h000, dc, dw, bc, st, dt, cc, cd, r, m);
    checks++;
    if (st[11:1] !== exp_sce[11:1]) begin errors++; $display("FAIL wave_sce got %b want %b", st[11:1], exp_sce[11:1]); end
    checks++;
    if (dt[11:1] !== exp_scd[11:1]) begin errors++; $display("FAIL wave_scd got %b want %b", dt[11:1], exp_scd[11:1]); end
  endtask

  task automatic test_reset_abort;
    int dc, dw, bc, seen_done, seen_busy;
    logic [11:0] st, dt;
    logic [N-1:0] cc, cd, r;
    logic m;
    exp_t e;
    @(negedge CLK);
    pattern = 4'b1011;
    expected = 4'b0110;
    cap_fixed = 4'b0110;
    mirror = 1'b0;
    start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    checks++;
    if (sce !== 1'b1) begin errors++; $display("FAIL abort_pre_sce got %b want 1", sce); end
    #2 RESETB = 1'b0;
    #1;
    checks++;
    if ({sce, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_ctrl got %b want 000", {sce, busy, done}); end
    checks++;
    if (response !== '0) begin errors++; $display("FAIL abort_rsp got %b want 0000", response); end
    @(negedge CLK);
    RESETB = 1'b1;
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done) seen_done++;
      if (busy) seen_busy++;
    end
    checks++;
    if (seen_done + seen_busy != 0) begin
      errors++;
      $display("FAIL abort_quiet got done %0d busy %0d want 0 0", seen_done, seen_busy);
    end
    exp_q.push_back('{rsp: 4'b0110, mm: 1'b0});
    run_seq(4'b1011, 4'b0110, 4'b0110, 1'b0, 1'b0, 12'h000, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e.rsp || dc != 2 * N + 2) begin
      errors++;
      $display("FAIL abort_rerun got rsp %b at cycle %0d want %b at %0d", r, dc, e.rsp, 2 * N + 2);
    end
  endtask

  task automatic test_start_ignored;
    int dc, dw, bc;
    logic [11:0] st, dt;
    logic [N-1:0] cc, cd, r;
    logic m;
    exp_t e;
    exp_q.push_back('{rsp: 4'b1001, mm: 1'b1});
    // start in LOAD (2), UNLOAD (7), DONE (10), then in the first IDLE cycle (11)
    run_seq(4'b0101, 4'b1000, 4'b1001, 1'b0, 1'b0, 12'hC84, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (dc != 2 * N + 2 || dw != 1) begin
      errors++;
      $display("FAIL ign_latency got cycle %0d width %0d want %0d 1", dc, dw, 2 * N + 2);
    end
    checks++;
    if (bc != 2 * N + 1) begin errors++; $display("FAIL ign_busy_cycles got %0d want %0d", bc, 2 * N + 1); end
    checks++;
    if (r !== e.rsp || m !== e.mm) begin
      errors++;
      $display("FAIL ign_result got %b/%b want %b/%b", r, m, e.rsp, e.mm);
    end
    exp_q.push_back('{rsp: 4'b1001, mm: 1'b1});
    run_seq(4'b0101, 4'b1000, 4'b1001, 1'b0, 1'b1, 12'h000, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (dc != 2 * N + 2 || r !== e.rsp) begin
      errors++;
      $display("FAIL ign_restart got rsp %b at cycle %0d want %b at %0d", r, dc, e.rsp, 2 * N + 2);
    end
  endtask

  task automatic test_back_to_back;
    int dc, dw, bc;
    logic [11:0] st, dt;
    logic [N-1:0] cc, cd, r;
    logic m;
    exp_t e;
    exp_q.push_back('{rsp: 4'hF, mm: 1'b0});
    run_seq(4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 12'h800, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e.rsp || m !== e.mm) begin
      errors++;
      $display("FAIL b2b_first got %h/%b want %h/%b", r, m, e.rsp, e.mm);
    end
    exp_q.push_back('{rsp: 4'h0, mm: 1'b0});
    run_seq(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 12'h000, dc, dw, bc, st, dt, cc, cd, r, m);
    e = exp_q.pop_front();
    checks++;
    if (r !== e.rsp || m !== e.mm || dc != 2 * N + 2) begin
      errors++;
      $display("FAIL b2b_second got %h/%b at cycle %0d want %h/%b at %0d", r, m, dc, e.rsp, e.mm, 2 * N + 2);
    end
    mirror = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fault();
    test_waveform();
    test_reset_abort();
    test_start_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
